pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline-boundary register; the next generation of the 32-bit stall/enable register used for the PC and inter-stage latches.
- Generalised in width, reset value and bubble value.
- Adds a valid bit, flush-to-bubble, and a saturating stall-cycle performance counter.
- One instance is placed at each boundary: PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

Parameters:
- WIDTH, 32, payload width in bits.
- RESET_VALUE, 0, payload value loaded on reset (PC instance: reset vector).
- BUBBLE_VALUE, 0, payload value loaded on flush (32'h00000000 = NOP).
- CNT_WIDTH, 16, width of the stall-cycle counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- CE  input  1  load enable.
- stall  input  1  hold current contents.
- flush  input  1  replace contents with a bubble.
- D  input  WIDTH  payload in.
- valid_in  input  1  payload-in valid.
- cnt_clr  input  1  synchronous clear of stall_cnt.
- Q  output  WIDTH  registered payload.
- valid_out  output  1  registered valid.
- stall_cnt  output  CNT_WIDTH  count of stalled cycles, saturating.
- cnt_sat  output  1  stall_cnt at all-ones.

Behaviour:
- Reset: rst=1 asynchronously forces Q=RESET_VALUE, valid_out=0, stall_cnt=0, cnt_sat=0. Reset takes effect immediately, mid-stall or mid-flush. The first load occurs at the first rising edge after rst deasserts.
- All other updates occur on the rising edge of clk. Latency D→Q is 1 cycle. All outputs are registered; there is no combinational path from input to output.
- Payload/valid priority per edge, highest first:
  - flush=1: Q<=BUBBLE_VALUE, valid_out<=0. Flush wins over stall and CE.
  - stall=1: Q and valid_out hold. Stall wins over CE.
  - CE=1: Q<=D, valid_out<=valid_in.
  - Otherwise: hold.
- A stalled stage that is flushed becomes a bubble on that same edge.
- valid_in is sampled only when a load occurs. D is not qualified by valid_in: an invalid payload is still loaded into Q.
- Stall counter, per edge:
  - cnt_clr=1: stall_cnt<=0. Clear wins over increment on the same edge.
  - Else if stall=1, flush=0 and valid_out=1: stall_cnt increments by 1.
  - Stalls on a bubble are not counted.
- Counter saturation: stall_cnt stops at 2^CNT_WIDTH-1 and never wraps.
- cnt_sat is registered and equals (stall_cnt == all-ones). It is updated on the same edge as stall_cnt.
- Unsigned arithmetic only. The increment is computed at CNT_WIDTH+1 bits, or guarded by cnt_sat.
- X-safety: with CE=0, stall=0, flush=0, the outputs hold and D is ignored.

Decomposition:
- Shared package (pipe_pkg):
  - NOP_INSTR = 32'h00000000.
  - PC_RESET_VECTOR = 32'h00000000.
  - Default CNT_WIDTH.
- One sub-module: sat_counter, with parameter W and ports clk, rst, clr, inc, cnt, sat. It implements the saturating stall counter.
- The payload/valid datapath stays in pipe_stage_reg.

Test Plan:
1. Reset mid-operation:
   - Stimulus: load D=32'hDEADBEEF with valid_in=1, then assert rst between clock edges.
   - Required: Q=RESET_VALUE, valid_out=0 and stall_cnt=0 immediately, without waiting for a clock edge.
2. Basic load:
   - Stimulus: CE=1, D=32'h00400004, valid_in=1 at edge N.
   - Required: Q=32'h00400004 and valid_out=1 after edge N.
   - Stimulus: CE=0 with D changed.
   - Required: Q unchanged.
3. Stall hold and count:
   - Stimulus: Q=32'h12345678 valid, then stall=1 for 5 edges while CE=1 and D varies.
   - Required: Q stays 32'h12345678, valid_out=1, stall_cnt=5.
4. Flush priority:
   - Stimulus: stall=1, flush=1, CE=1 on the same edge.
   - Required: Q=BUBBLE_VALUE, valid_out=0, and stall_cnt unchanged on that edge.
   - Stimulus: a subsequent stall while the stage holds the bubble.
   - Required: stall_cnt does not increment.
5. Saturation and clear:
   - Stimulus: CNT_WIDTH=4, valid stage, stall held for 20 edges.
   - Required: stall_cnt=15, cnt_sat=1, no wrap.
   - Stimulus: cnt_clr=1 together with stall=1.
   - Required: stall_cnt=0, cnt_sat=0.
6. Parameter sweep:
   - Stimulus: WIDTH=8 with RESET_VALUE=8'hA5 and BUBBLE_VALUE=8'h3C.
   - Required: Q=8'hA5 after reset, and Q=8'h3C after a flush.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants for the pipeline-boundary registers
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR         = 32'h00000000;
    localparam logic [31:0] PC_RESET_VECTOR   = 32'h00000000;
    localparam int          DEFAULT_CNT_WIDTH = 16;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear and registered saturation flag
module sat_counter
    import pipe_pkg::*;
#(
    parameter int W = DEFAULT_CNT_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         sat_q, sat_d;
    logic [W:0]   cnt_inc;

    always_comb begin
        cnt_inc = {1'b0, cnt_q} + {{W{1'b0}}, 1'b1};
        cnt_d   = cnt_q;
        // A carry out of the top bit means the count is already all-ones: hold it.
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !cnt_inc[W]) begin
            cnt_d = cnt_inc[W-1:0];
        end
        sat_d = &cnt_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    assign cnt = cnt_q;
    assign sat = sat_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline-boundary register with valid bit, flush-to-bubble and stall counter
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE  = WIDTH'(PC_RESET_VECTOR),
    parameter logic [WIDTH-1:0] BUBBLE_VALUE = WIDTH'(NOP_INSTR),
    parameter int               CNT_WIDTH    = DEFAULT_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 CE,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [WIDTH-1:0]     D,
    input  logic                 valid_in,
    input  logic                 cnt_clr,
    output logic [WIDTH-1:0]     Q,
    output logic                 valid_out,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic                 cnt_sat
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             valid_q, valid_d;
    logic             stall_inc;

    // Priority: flush > stall > load > hold.
    always_comb begin
        q_d     = q_q;
        valid_d = valid_q;
        if (flush) begin
            q_d     = BUBBLE_VALUE;
            valid_d = 1'b0;
        end else if (!stall && CE) begin
            q_d     = D;
            valid_d = valid_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q     <= RESET_VALUE;
            valid_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            valid_q <= valid_d;
        end
    end

    // Only stalls that hold a real instruction are counted.
    assign stall_inc = stall && !flush && valid_q;

    sat_counter #(
        .W (CNT_WIDTH)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (stall_inc),
        .cnt (stall_cnt),
        .sat (cnt_sat)
    );

    assign Q         = q_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

    logic        clk;
    logic        rst;
    logic        ce;
    logic        stall;
    logic        flush;
    logic [31:0] d;
    logic        valid_in;
    logic        cnt_clr;

    logic [31:0] qa;
    logic        va;
    logic [3:0]  cnta;
    logic        sata;

    logic [7:0]  db;
    logic [7:0]  qb;
    logic        vb;
    logic [15:0] cntb;
    logic        satb;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    // Reference model state
    logic [31:0] ma_q;
    logic        ma_v;
    int          ma_cnt;
    logic [7:0]  mb_q;
    logic        mb_v;
    int          mb_cnt;

    assign db = d[7:0];

    pipe_stage_reg #(
        .WIDTH        (32),
        .RESET_VALUE  (32'h00000000),
        .BUBBLE_VALUE (32'h00000000),
        .CNT_WIDTH    (4)
    ) dut_a (
        .clk       (clk),
        .rst       (rst),
        .CE        (ce),
        .stall     (stall),
        .flush     (flush),
        .D         (d),
        .valid_in  (valid_in),
        .cnt_clr   (cnt_clr),
        .Q         (qa),
        .valid_out (va),
        .stall_cnt (cnta),
        .cnt_sat   (sata)
    );

    pipe_stage_reg #(
        .WIDTH        (8),
        .RESET_VALUE  (8'hA5),
        .BUBBLE_VALUE (8'h3C),
        .CNT_WIDTH    (16)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .CE        (ce),
        .stall     (stall),
        .flush     (flush),
        .D         (db),
        .valid_in  (valid_in),
        .cnt_clr   (cnt_clr),
        .Q         (qb),
        .valid_out (vb),
        .stall_cnt (cntb),
        .cnt_sat   (satb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: apply the stage rules to the state seen just before the edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma_q = 32'h00000000; ma_v = 1'b0; ma_cnt = 0;
            mb_q = 8'hA5;        mb_v = 1'b0; mb_cnt = 0;
        end else begin
            if (cnt_clr) begin
                ma_cnt = 0;
                mb_cnt = 0;
            end else if (stall && !flush) begin
                if (ma_v) ma_cnt = (ma_cnt + 1 > 15) ? 15 : ma_cnt + 1;
                if (mb_v) mb_cnt = (mb_cnt + 1 > 65535) ? 65535 : mb_cnt + 1;
            end
            if (flush) begin
                ma_q = 32'h00000000; ma_v = 1'b0;
                mb_q = 8'h3C;        mb_v = 1'b0;
            end else if (!stall && ce) begin
                ma_q = d;      ma_v = valid_in;
                mb_q = d[7:0]; mb_v = valid_in;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("a_q",     qa,                ma_q);
            check("a_valid", {31'b0, va},       {31'b0, ma_v});
            check("a_cnt",   {28'b0, cnta},     32'(ma_cnt));
            check("a_sat",   {31'b0, sata},     {31'b0, ma_cnt == 15});
            check("b_q",     {24'b0, qb},       {24'b0, mb_q});
            check("b_valid", {31'b0, vb},       {31'b0, mb_v});
            check("b_cnt",   {16'b0, cntb},     32'(mb_cnt));
            check("b_sat",   {31'b0, satb},     {31'b0, mb_cnt == 65535});
        end
    end

    task automatic drive(input logic c, input logic s, input logic f,
                         input logic [31:0] dv, input logic vi, input logic clr);
        ce = c; stall = s; flush = f; d = dv; valid_in = vi; cnt_clr = clr;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 32'h0, 0, 0);
        #2;
        check("rst_a_q", qa, 32'h00000000);
        check("rst_b_q", {24'b0, qb}, 32'h000000A5);
        check("rst_a_valid", {31'b0, va}, 32'h0);
        tick();
        rst = 1'b0;
        chk_en = 1;

        // Load then asynchronous reset between edges
        drive(1, 0, 0, 32'hDEADBEEF, 1, 0);
        tick();
        check("load_deadbeef", qa, 32'hDEADBEEF);
        #2 rst = 1'b1;
        #1;
        check("async_rst_q", qa, 32'h00000000);
        check("async_rst_valid", {31'b0, va}, 32'h0);
        check("async_rst_b_q", {24'b0, qb}, 32'h000000A5);
        tick();
        rst = 1'b0;

        // Basic load, then CE=0 ignores D
        drive(1, 0, 0, 32'h00400004, 1, 0);
        tick();
        check("basic_load_q", qa, 32'h00400004);
        check("basic_load_valid", {31'b0, va}, 32'h1);
        drive(0, 0, 0, 32'hFFFF0000, 0, 0);
        tick();
        check("ce0_hold_q", qa, 32'h00400004);

        // Stall hold and count
        drive(1, 0, 0, 32'h12345678, 1, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 32'h1000 + i, 0, 0);
            tick();
        end
        check("stall_hold_q", qa, 32'h12345678);
        check("stall_hold_valid", {31'b0, va}, 32'h1);
        check("stall_cnt5", {28'b0, cnta}, 32'd5);

        // Flush wins over stall and CE; stalls on a bubble are not counted
        drive(1, 1, 1, 32'hCAFEF00D, 1, 0);
        tick();
        check("flush_q", qa, 32'h00000000);
        check("flush_b_q", {24'b0, qb}, 32'h0000003C);
        check("flush_valid", {31'b0, va}, 32'h0);
        check("flush_cnt", {28'b0, cnta}, 32'd5);
        drive(1, 1, 0, 32'h0, 1, 0);
        tick();
        check("bubble_stall_cnt", {28'b0, cnta}, 32'd5);

        // Saturation then clear-with-stall
        drive(1, 0, 0, 32'h00000ABC, 1, 0);
        tick();
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 0, 32'h0, 1, 0);
            tick();
        end
        check("sat_cnt", {28'b0, cnta}, 32'd15);
        check("sat_flag", {31'b0, sata}, 32'h1);
        check("b_cnt25", {16'b0, cntb}, 32'd25);
        drive(1, 1, 0, 32'h0, 1, 1);
        tick();
        check("clr_cnt", {28'b0, cnta}, 32'd0);
        check("clr_sat", {31'b0, sata}, 32'h0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 40) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b1;
                #1;
                check("rand_async_rst_q", qa, 32'h00000000);
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
